// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg
// Shared definitions for the accumulator drain controller:
//   - default parameter constants for acc_drain
//   - FSM state encoding
//   - depth_log2(): tap-select width, at least 1 bit
package acc_drain_pkg;

    localparam int ACC_DRAIN_WIDTH      = 32;
    localparam int ACC_DRAIN_DEPTH      = 4;
    localparam int ACC_DRAIN_LEN_W      = 16;
    localparam int ACC_DRAIN_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_PUSH   = 2'd3
    } state_t;

    // A single-tap accumulator still needs a 1-bit select port.
    function automatic int depth_log2(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/acc_drain_fifo.sv
// acc_drain_fifo
// First-word-fall-through output buffer for drained accumulator results.
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the buffer)
//   push, push_data write request / data; ignored while full, even when a
//                   pop happens in the same cycle
//   pop_ready       downstream ready; a pop happens when out_valid & pop_ready
//   out_valid       buffer not empty
//   out_data        head entry, zero when empty
//   full            buffer holds FIFO_DEPTH entries
// FIFO_DEPTH must be a power of two, >= 2.
module acc_drain_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_push  = push & ~full;
    assign w_pop   = pop_ready & ~w_empty;

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage has no reset; emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_drain.sv
// acc_drain
// Sequences an external accumulator over a command's multiplier beats, then
// drains the settled result into a small output stream buffer.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high
// ACC    | one res_en per mult_valid beat; first beat loads, later feed back
// SETTLE | one dead cycle so res_cascade reflects the final beat
// PUSH   | write res_cascade to the buffer; hold here while it is full
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_len                     beats to accumulate (0 means 1)
//   cmd_depth                   accumulator tap to read out
//   mult_valid                  upstream multiplier result valid
//   res_en/res_mode/res_depth   accumulator control (mode 0 load, 1 feedback)
//   res_cascade                 accumulator result
//   out_data/out_valid/out_ready drained-result stream
//   busy                        controller not idle
//   drained_count               (ACC_DRAIN_CNT_EN only) count of out transfers
//
// Build option: define ACC_DRAIN_CNT_EN to add the drained_count port.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int WIDTH      = ACC_DRAIN_WIDTH,
    parameter int DEPTH      = ACC_DRAIN_DEPTH,
    parameter int LEN_W      = ACC_DRAIN_LEN_W,
    parameter int FIFO_DEPTH = ACC_DRAIN_FIFO_DEPTH,
    // Derived from DEPTH; leave at its default.
    parameter int DEPTH_LOG2 = depth_log2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [DEPTH_LOG2-1:0]   cmd_depth,
    input  logic                    mult_valid,
    output logic                    res_en,
    output logic                    res_mode,
    output logic [DEPTH_LOG2-1:0]   res_depth,
    input  logic signed [WIDTH-1:0] res_cascade,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
`ifdef ACC_DRAIN_CNT_EN
    ,
    output logic [31:0]             drained_count
`endif
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_depth;

    logic             w_beat;
    logic             w_last_beat;
    logic             w_push;
    logic             w_fifo_full;
    logic [WIDTH-1:0] w_fifo_data;

    assign w_beat      = (r_state == ST_ACC) & mult_valid;
    // r_len is never 0, so r_len - 1 is the index of the final beat.
    assign w_last_beat = w_beat & (r_cnt == (r_len - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= LEN_W'(1);
            r_cnt   <= '0;
            r_depth <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && cmd_valid) begin
                r_len   <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                r_depth <= cmd_depth;
                r_cnt   <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        res_en      = 1'b0;
        res_mode    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                res_en   = mult_valid;
                res_mode = mult_valid & (r_cnt != '0);
                if (w_last_beat) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                // Accumulator stays frozen (res_en low) until there is room.
                if (!w_fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign res_depth = r_depth;

    acc_drain_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (res_cascade),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (w_fifo_data),
        .full      (w_fifo_full)
    );

    assign out_data = $signed(w_fifo_data);

`ifdef ACC_DRAIN_CNT_EN
    logic [31:0] r_drained_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drained_count <= '0;
        end else if (out_valid && out_ready) begin
            r_drained_count <= r_drained_count + 32'd1;
        end
    end

    assign drained_count = r_drained_count;
`endif

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain
// Self-checking bench for acc_drain with default parameters. A behavioural
// accumulator model drives res_cascade from res_en/res_mode; expected results
// go to a scoreboard queue when a command's beats are driven and are popped
// when the output stream transfers a beat.
module tb_acc_drain;

    logic               clk;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [15:0]        cmd_len;
    logic [1:0]         cmd_depth;
    logic               mult_valid;
    logic               res_en;
    logic               res_mode;
    logic [1:0]         res_depth;
    logic signed [31:0] res_cascade;
    logic signed [31:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
`ifdef ACC_DRAIN_CNT_EN
    logic [31:0]        drained_count;
`endif

    acc_drain dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_depth   (cmd_depth),
        .mult_valid  (mult_valid),
        .res_en      (res_en),
        .res_mode    (res_mode),
        .res_depth   (res_depth),
        .res_cascade (res_cascade),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
`ifdef ACC_DRAIN_CNT_EN
        ,
        .drained_count (drained_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Accumulator stand-in: load on mode 0, add on mode 1.
    logic signed [31:0] mult_in;
    logic signed [31:0] r_acc = 0;
    always @(posedge clk) begin
        if (res_en) r_acc <= res_mode ? (r_acc + mult_in) : mult_in;
    end
    assign res_cascade = r_acc;

    // Scoreboard and output monitor (sampled mid-cycle).
    int                 exp_q[$];
    int                 pulses = 0;
    int                 xfers  = 0;
    logic               hold_prev = 1'b0;
    logic signed [31:0] data_prev = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold_prev <= 1'b0;
            xfers     <= 0;
        end else begin
            if (res_en) pulses <= pulses + 1;
            if (hold_prev && out_valid)
                chk("out_data_stable", out_data, data_prev);
            if (out_valid && out_ready) begin
                xfers <= xfers + 1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %0d, expected no beat", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            hold_prev <= out_valid & ~out_ready;
            data_prev <= out_data;
        end
    end

    typedef struct packed {
        int len;
        int depth;
        int gap;
        int v0;
        int v1;
        int v2;
        int v3;
        int exp_sum;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and drives its beats (max 4). With lat_chk, also
    // checks the SETTLE/PUSH/out_valid timing assuming an empty buffer.
    task automatic run_cmd(input vec_t v, input bit lat_chk);
        int vals[4];
        int n;
        int w;
        int p0;
        vals = '{v.v0, v.v1, v.v2, v.v3};
        n = (v.len == 0) ? 1 : v.len;
        w = 0;
        while (!cmd_ready && w < 200) begin
            tick();
            w++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        if (!cmd_ready) return;
        p0 = pulses;
        cmd_valid = 1'b1;
        cmd_len   = 16'(v.len);
        cmd_depth = 2'(v.depth);
        tick();
        cmd_valid = 1'b0;
        chk("res_depth", res_depth, v.depth);
        chk("busy_acc", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    mult_valid = 1'b0;
                    #1;
                    chk("res_en_stall", res_en, 0);
                    chk("busy_stall", busy, 1);
                    tick();
                end
            end
            mult_valid = 1'b1;
            mult_in    = vals[i];
            #1;
            chk("res_en_beat", res_en, 1);
            chk("res_mode_beat", res_mode, (i != 0) ? 1 : 0);
            tick();
        end
        mult_valid = 1'b0;
        exp_q.push_back(v.exp_sum);
        chk("settle_res_en", res_en, 0);
        chk("settle_res_mode", res_mode, 0);
        if (lat_chk) begin
            chk("settle_busy", busy, 1);
            chk("settle_out_valid", out_valid, 0);
            tick();
            chk("push_busy", busy, 1);
            chk("push_out_valid", out_valid, 0);
            tick();
            chk("lat_out_valid", out_valid, 1);
            chk("idle_busy", busy, 0);
            chk("res_en_pulses", pulses - p0, n);
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        //            len depth gap  v0      v1  v2  v3  sum
        vecs[0] = '{  3,  0,   0,   5,      7,  -2, 0,  10};
        vecs[1] = '{  0,  1,   0,   9,      0,  0,  0,  9};
        vecs[2] = '{  4,  2,   1,   1,      2,  3,  4,  10};
        vecs[3] = '{  1,  3,   0,   -100,   0,  0,  0,  -100};
        vecs[4] = '{  2,  1,   2,   100000, -1, 0,  0,  99999};
        vecs[5] = '{  4,  0,   0,   -5,     -5, -5, -5, -20};

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_depth  = '0;
        mult_valid = 1'b0;
        mult_in    = 0;
        out_ready  = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_en", res_en, 0);
        chk("rst_res_mode", res_mode, 0);
        chk("rst_res_depth", res_depth, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[k]) begin
            run_cmd(vecs[k], 1'b1);
            wait_drain();
        end

        // Backpressure: four results fill the buffer, the fifth waits in PUSH.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = '{1, 0, 0, 11 + k, 0, 0, 0, 11 + k};
            run_cmd(v, 1'b0);
        end
        repeat (4) tick();
        chk("bp_busy", busy, 1);
        chk("bp_res_en", res_en, 0);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", out_data, 11);
        chk("bp_queued", exp_q.size(), 5);
        out_ready = 1'b1;
        wait_drain();
        tick();
        chk("bp_idle", busy, 0);

        // Reset mid-command discards buffered and in-flight results.
        out_ready = 1'b0;
        v = '{1, 0, 0, 77, 0, 0, 0, 77};
        run_cmd(v, 1'b0);
        repeat (3) tick();
        chk("pre_rst_out_valid", out_valid, 1);
        cmd_valid = 1'b1;
        cmd_len   = 16'd8;
        cmd_depth = 2'd3;
        tick();
        cmd_valid = 1'b0;
        chk("mid_res_depth", res_depth, 3);
        mult_valid = 1'b1;
        mult_in    = 1;
        tick();
        mult_in    = 2;
        tick();
        chk("mid_busy", busy, 1);
        mult_valid = 1'b0;
        reset      = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_res_en", res_en, 0);
        chk("mrst_res_depth", res_depth, 0);
        chk("mrst_out_data", out_data, 0);
`ifdef ACC_DRAIN_CNT_EN
        chk("mrst_drained_count", drained_count, 0);
`endif
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        v = '{2, 2, 0, 3, 4, 0, 0, 7};
        run_cmd(v, 1'b1);
        wait_drain();

`ifdef ACC_DRAIN_CNT_EN
        tick();
        chk("drained_count", drained_count, xfers);
        chk("drained_count_one", drained_count, 1);
        reset = 1'b1;
        tick();
        chk("drained_count_rst", drained_count, 0);
        reset = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
